serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/serial_subtractor_full_adder.sv | 16 +
 rtl/serial_subtractor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM state
// type and the signed-overflow rule used when the result is published.
package serial_subtractor_pkg;

    // Default operand/result width.
    localparam int SUB_NBITS = 8;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    // Signed overflow of a - b: operands of opposite sign and the result sign
    // differs from the minuend sign.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic s_msb);
        return (a_msb != b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// One-bit full adder; the serial datapath reuses it once per bit-cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the parity of the inputs, carry is their majority.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor. Computes A - B as A + ~B + 1, one
// bit per clock, LSB first, through a single full adder. Results and flags
// are published together with a one-cycle done pulse and held until the next.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int NBITS = SUB_NBITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [NBITS-1:0] A,
    input  logic signed [NBITS-1:0] B,
    output logic                    busy,
    output logic                    done,
    output logic signed [NBITS-1:0] S,
    output logic                    N,
    output logic                    Z,
    output logic                    P,
    output logic                    V
);

    // One extra bit so the counter can never wrap before the last bit.
    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    sub_state_e       state_q,  state_d;
    logic [NBITS-1:0] a_sh_q,   a_sh_d;
    logic [NBITS-1:0] b_sh_q,   b_sh_d;
    logic [NBITS-1:0] res_q,    res_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic [NBITS-1:0] s_q,      s_d;
    logic             n_q,      n_d;
    logic             z_q,      z_d;
    logic             p_q,      p_d;
    logic             v_q,      v_d;
    logic             done_q,   done_d;

    logic             b_inv;
    logic             fa_s;
    logic             fa_cout;

    // Subtrahend bit is inverted on its way into the adder; the +1 comes
    // from the carry being preset on start.
    assign b_inv = ~b_sh_q[0];

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_inv),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next-state logic for the controller, shift datapath and result outputs.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        s_d      = s_q;
        n_d      = n_q;
        z_d      = z_q;
        p_d      = p_q;
        v_d      = v_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    res_d    = '0;
                    cnt_d    = '0;
                    carry_d  = 1'b1;
                    // Shift registers lose the sign bits, so keep copies
                    // for the overflow decision.
                    a_sign_d = A[NBITS-1];
                    b_sign_d = B[NBITS-1];
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                // Sum bits enter at the top; after NBITS shifts bit 0 of the
                // result has reached the bottom.
                res_d   = {fa_s, res_q[NBITS-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Only here does the finished result reach the outputs, so
                // partial sums are never visible on S.
                s_d     = res_q;
                n_d     = res_q[NBITS-1];
                z_d     = (res_q == '0);
                p_d     = ~res_q[0];
                v_d     = sub_overflow(a_sign_q, b_sign_q, res_q[NBITS-1]);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            s_q      <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            p_q      <= 1'b1;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            s_q      <= s_d;
            n_q      <= n_d;
            z_q      <= z_d;
            p_q      <= p_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign S    = s_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign P    = p_q;
    assign V    = v_q;

endmodule
